// File: rtl/rs232_tx_arbiter_if.sv
// ============================================================================
// Module   : rs232_tx_arbiter_if
// Brief    : Two-requester valid/ready byte handshake bundle for the TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs232_tx_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready
   );
endinterface

`default_nettype wire

// File: rtl/rs232_tx_arbiter.sv
// ============================================================================
// Module   : rs232_tx_arbiter
// Brief    : Round-robin two-way arbiter feeding an 8N1 RS232 frame serialiser.
//            Define RS232_TX_PARITY_EN for an 8E1 frame with even parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232_tx_arbiter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   rs232_tx_arbiter_if.slave  req,
   output logic              tx,
   output logic              busy,
   output logic              active_id,
   output logic              frame_done
);

   localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_PRE  = c_CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef RS232_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit;
   logic [7:0]         r_shift;
   logic               r_tx;
   logic               r_busy;
   logic               r_active_id;
   logic               r_last_grant;
   logic               r_frame_done;
`ifdef RS232_TX_PARITY_EN
   logic               r_parity;
`endif

   logic       w_idle;
   logic       w_pick1;
   logic       w_grant0;
   logic       w_grant1;
   logic [7:0] w_data;

   // On a tie the requester that did not win last time takes the grant.
   assign w_idle   = (r_state == S_IDLE);
   assign w_pick1  = req.req1_valid & (~req.req0_valid | ~r_last_grant);
   assign w_grant1 = w_idle & w_pick1;
   assign w_grant0 = w_idle & req.req0_valid & ~w_pick1;
   assign w_data   = w_pick1 ? req.req1_data : req.req0_data;

   assign req.req0_ready = w_grant0;
   assign req.req1_ready = w_grant1;

   assign tx         = r_tx;
   assign busy       = r_busy;
   assign active_id  = r_active_id;
   assign frame_done = r_frame_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_active_id  <= 1'b0;
         r_last_grant <= 1'b1;
         r_frame_done <= 1'b0;
`ifdef RS232_TX_PARITY_EN
         r_parity     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx         <= 1'b1;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
               if (w_grant0 | w_grant1) begin
                  r_shift      <= w_data;
                  r_active_id  <= w_pick1;
                  r_last_grant <= w_pick1;
`ifdef RS232_TX_PARITY_EN
                  r_parity     <= ^w_data;
`endif
                  r_state      <= S_START;
                  r_cnt        <= '0;
                  r_tx         <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end

            S_START: begin
               if (r_cnt == c_LAST) begin
                  r_state <= S_DATA;
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + c_ONE;
               end
            end

            // tx is registered, so the next bit is taken from shift[1] as we shift.
            S_DATA: begin
               if (r_cnt == c_LAST) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
`ifdef RS232_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_parity;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + c_ONE;
               end
            end

`ifdef RS232_TX_PARITY_EN
            S_PARITY: begin
               if (r_cnt == c_LAST) begin
                  r_state <= S_STOP;
                  r_cnt   <= '0;
                  r_tx    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + c_ONE;
               end
            end
`endif

            S_STOP: begin
               if (r_cnt == c_LAST) begin
                  r_state      <= S_IDLE;
                  r_cnt        <= '0;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b0;
                  r_tx         <= 1'b1;
               end else begin
                  r_cnt        <= r_cnt + c_ONE;
                  r_frame_done <= (r_cnt == c_PRE);
               end
            end

            default: begin
               r_state      <= S_IDLE;
               r_tx         <= 1'b1;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rs232_tx_arbiter.sv
// ============================================================================
// Module   : tb_rs232_tx_arbiter
// Brief    : Scoreboard bench for rs232_tx_arbiter (CLKS_PER_BIT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rs232_tx_arbiter;

   localparam int C = 4;
`ifdef RS232_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FL = NBITS * C;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tx, busy, active_id, frame_done;

   always #5 clk = ~clk;

   rs232_tx_arbiter_if bus ();

   rs232_tx_arbiter #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (bus),
      .tx         (tx),
      .busy       (busy),
      .active_id  (active_id),
      .frame_done (frame_done)
   );

   typedef struct {
      logic       id;
      logic [7:0] data;
      int         abort_at;
      int         spacing;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Bit k of the result is the tx level during bit slot k of the frame.
   function automatic logic [10:0] frame_bits(input logic [7:0] d);
      logic [10:0] b;
      b      = '1;
      b[0]   = 1'b0;
      b[8:1] = d;
`ifdef RS232_TX_PARITY_EN
      b[9]   = ^d;
`endif
      return b;
   endfunction

   function automatic exp_t mk(input logic id, input logic [7:0] d, input int ab, input int sp);
      exp_t e;
      e.id = id; e.data = d; e.abort_at = ab; e.spacing = sp;
      return e;
   endfunction

   // Monitor: idle invariants between frames, then a full frame check per acceptance.
   initial begin : monitor
      exp_t        e;
      int          last_acc;
      logic [10:0] bits;
      last_acc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         check("idle_tx", tx, 1);
         check("idle_busy", busy, 0);
         check("idle_frame_done", frame_done, 0);
         if (bus.req0_ready && bus.req1_ready) begin
            checks++; errors++;
            $display("FAIL both_ready actual=11 required=one-hot (cycle %0d)", cyc);
         end else if (bus.req0_ready || bus.req1_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_accept actual=id%0d required=none (cycle %0d)",
                        bus.req1_ready, cyc);
            end else begin
               e = q.pop_front();
               check("accept_id", bus.req1_ready, e.id);
               if (e.spacing != 0) check("accept_spacing", cyc - last_acc, e.spacing);
               last_acc = cyc;
               bits = frame_bits(e.data);
               for (int t = 1; t <= FL; t++) begin
                  @(negedge clk);
                  cyc++;
                  if (e.abort_at != 0 && t >= e.abort_at) begin
                     check("abort_tx", tx, 1);
                     check("abort_busy", busy, 0);
                     check("abort_frame_done", frame_done, 0);
                  end else begin
                     check("busy", busy, 1);
                     check("frame_done", frame_done, (t == FL) ? 1 : 0);
                     if (t == 1) check("active_id", active_id, e.id);
                     if ((t - 1) % C == C / 2)
                        check($sformatf("tx_bit%0d", (t - 1) / C), tx, bits[(t - 1) / C]);
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic id, input logic [7:0] d);
      int n;
      @(posedge clk); #1;
      if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
      else    begin bus.req0_valid = 1'b1; bus.req0_data = d; end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(id ? bus.req1_ready : bus.req0_ready) && n < 200);
      if (!(id ? bus.req1_ready : bus.req0_ready)) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=no_ready required=ready id=%0d", id);
      end
      @(posedge clk); #1;
      // Scramble the data after acceptance: the frame must use the latched byte.
      if (id) begin bus.req1_valid = 1'b0; bus.req1_data = ~d; end
      else    begin bus.req0_valid = 1'b0; bus.req0_data = ~d; end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : stimulus
      int n, acc;
      bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
      bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      idle(20);

      q.push_back(mk(1'b0, 8'hA5, 0, 0));
      send(1'b0, 8'hA5);
      idle(FL + 5);

      // Reset in cycle 15 of a frame drops it; reset also restores last_grant=1.
      q.push_back(mk(1'b0, 8'hF0, 15, 0));
      send(1'b0, 8'hF0);
      repeat (14) @(posedge clk);
      #2 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      idle(FL);

      q.push_back(mk(1'b1, 8'h3C, 0, 0));
      send(1'b1, 8'h3C);
      idle(FL + 5);

      // Continuous contention: alternating grants at the minimum spacing.
      q.push_back(mk(1'b0, 8'h55, 0, 0));
      q.push_back(mk(1'b1, 8'h0F, 0, FL + 1));
      q.push_back(mk(1'b0, 8'h55, 0, FL + 1));
      q.push_back(mk(1'b1, 8'h0F, 0, FL + 1));
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h55;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h0F;
      n = 0; acc = 0;
      while (acc < 4 && n < 4 * (FL + 1) + 50) begin
         @(negedge clk);
         n++;
         if (bus.req0_ready || bus.req1_ready) acc++;
      end
      if (acc < 4) begin
         checks++; errors++;
         $display("FAIL contention_timeout actual=%0d required=4", acc);
      end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      idle(FL + 5);

      // A one-cycle req1 pulse while busy must be ignored entirely.
      q.push_back(mk(1'b0, 8'hC3, 0, 0));
      send(1'b0, 8'hC3);
      idle(5);
      bus.req1_valid = 1'b1; bus.req1_data = 8'hAA;
      idle(1);
      bus.req1_valid = 1'b0;
      idle(FL + 10);

`ifdef RS232_TX_PARITY_EN
      q.push_back(mk(1'b0, 8'h07, 0, 0));
      send(1'b0, 8'h07);
      idle(FL + 5);
      q.push_back(mk(1'b1, 8'h03, 0, 0));
      send(1'b1, 8'h03);
      idle(FL + 5);
`endif

      idle(10);
      check("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Frame controller and two-way arbiter for the RS232 transmit path. It accepts bytes from two requesters over valid/ready handshakes and picks one round-robin. It serialises the chosen byte LSB-first as an 8N1 frame at a fixed bit period and drives the idle-high serial line. It sits between the command/loopback sources and the TX pin, replacing ad-hoc parallel-to-serial conversion with a timed, bit-accurate frame sequence.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; the counter width is $clog2(CLKS_PER_BIT).
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte to send.
- req0_data  in  8  requester 0 byte; sampled only on acceptance.
- req0_ready  out  1  one-cycle pulse: the req0 byte was accepted this cycle.
- req1_valid  in  1  requester 1 has a byte to send.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  one-cycle pulse: the req1 byte was accepted this cycle.
- tx  out  1  serial line, idle high.
- busy  out  1  high whenever the FSM is outside IDLE.
- active_id  out  1  requester that owns the current or most recent frame.
- frame_done  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Each non-IDLE state holds for CLKS_PER_BIT cycles. The bit counter clears on every state entry.
- In IDLE, when any valid is high:
  - The block accepts exactly one request in that cycle.
  - It raises that requester's ready, latches its data into the shift register, latches active_id, and moves to START.
- Arbitration: if only one valid is high, that requester wins. If both are high, the requester not recorded in last_grant wins. last_grant updates on every acceptance.
- Both readies are never high in the same cycle. Neither ready is high outside IDLE.
- tx levels by state: START drives 0. DATA drives shift[0], shifting right after each bit, for 8 bits (index 0..7). STOP drives 1. IDLE drives 1.
- DATA exits after bit 7 to PARITY if the macro is enabled, otherwise to STOP.
- STOP exits to IDLE. frame_done pulses in the last STOP cycle.
- A valid that drops before acceptance is ignored. Data is not re-sampled after acceptance.

## Timing
- Reset values: tx=1, busy=0, req0_ready=0, req1_ready=0, frame_done=0, active_id=0, last_grant=1 (so req0 wins the first tie), shift=0, state IDLE.
- Reset asserted mid-frame: outputs return to reset values asynchronously, and the in-flight byte is dropped with no frame_done.
- Latency: acceptance in cycle N gives tx=0 from cycle N+1. The first data bit appears at N+1+CLKS_PER_BIT.
- Frame length: 10*CLKS_PER_BIT cycles from START entry to IDLE entry (11*CLKS_PER_BIT with parity).
- Back-to-back: the FSM spends at least one cycle in IDLE between frames. The minimum accept-to-accept spacing is frame length + 1 cycle, and tx stays high during that extra cycle.
- busy rises in cycle N+1 and falls on IDLE entry.

## Configuration
- RS232_TX_PARITY_EN defined:
  - The PARITY state is inserted after DATA and drives the even parity bit (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - The frame is 8E1, 11 bits.
- Undefined: no PARITY state, 8N1 frame, 10 bits. No parity logic is synthesised.

## Test plan
- Reset, then hold idle for 20 cycles -> tx=1, busy=0, both readies 0 throughout.
- CLKS_PER_BIT=4, req0 sends 8'hA5 ->
  - req0_ready pulses once; active_id=0.
  - tx is sampled at the bit centres 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 1,0,1,0,0,1,0,1, stop).
  - frame_done pulses at cycle 40 after acceptance.
- Both valid high continuously with req0=8'h55 and req1=8'h0F -> accept order is req0, req1, req0, req1; accept-to-accept spacing is exactly 41 cycles.
- Assert rst low at cycle 15 of a frame (CLKS_PER_BIT=4) -> tx=1 and busy=0 immediately, no frame_done; the next request frames correctly.
- With RS232_TX_PARITY_EN, send 8'h07 -> parity bit 1 and a 44-cycle frame. Send 8'h03 -> parity bit 0.
- Pulse req1_valid for one cycle while busy -> no req1_ready is issued and no frame is sent for it.
